divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; width fixed at 10 bits; number format unsigned fixed-point Q6.4 (6 integer bits, 4 fraction bits, LSB = 1/16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 sclr  input  1  reset is synchronous and active-low (sclr=0 clears on the next rising clk edge).
REQ-004 a_in  input  10  dividend, unsigned Q6.4.
REQ-005 b_in  input  10  divisor, unsigned Q6.4.
REQ-006 start  input  1  level request; sampled only in IDLE.
REQ-007 q_out  output  10  quotient, unsigned Q6.4, truncated toward zero.
REQ-008 dvz  output  1  divide-by-zero flag for the last operation.
REQ-009 ovf  output  1  overflow flag for the last operation.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 valid  output  1  one-cycle pulse when q_out/dvz/ovf become valid.

Function
REQ-012 States SHALL be IDLE, CALC, DONE; DONE always returns to IDLE on the next edge.
REQ-013 In IDLE, an edge with start=1 SHALL capture a_in and b_in into internal registers, clear dvz/ovf, set busy=1 and enter CALC; operands changing afterwards SHALL NOT affect the result.
REQ-014 If captured b=0, the next edge SHALL enter DONE with dvz=1, ovf=0, q_out=0; no iterations run.
REQ-015 Otherwise CALC SHALL perform 14 restoring shift-subtract iterations, one per edge, on numerator a·16 (14 bits) by b, producing a 14-bit integer quotient Q = floor(a·16/b).
REQ-016 On the 14th iteration edge, the block SHALL enter DONE and register the result: if Q[13:10]≠0 then ovf=1 and q_out=10'h3FF (saturate); else ovf=0 and q_out=Q[9:0].
REQ-017 Latency: valid SHALL be high during the cycle following the 14th CALC edge (15 edges after the start-sampling edge); 2 edges for dvz case.
REQ-018 busy SHALL be 1 from the start-sampling edge until the edge entering DONE; busy=0 while valid=1.
REQ-019 q_out, dvz, ovf SHALL hold their values after valid falls until the next start is accepted.
REQ-020 start held high continuously SHALL launch a new operation on the first edge back in IDLE (one idle cycle between operations); start during CALC/DONE is ignored.
REQ-021 Remainder is discarded; no rounding.

Reset
REQ-022 sclr=0 at a rising edge SHALL force IDLE, q_out=0, dvz=0, ovf=0, busy=0, valid=0 and clear internal registers, including mid-CALC (operation aborted, no valid pulse).
REQ-023 sclr SHALL take priority over start on the same edge.

Structure
REQ-024 Shared package SHALL hold WIDTH=10, FRAC=4, ITER=14 and the state enumeration type.
REQ-025 One sub-module is natural: divider_datapath (operand/remainder/quotient registers and subtractor), controlled by an FSM in divider; a single module is also acceptable.

Verification
REQ-026 a=0101010000 (21.0), b=0000000100 (0.25) -> ovf=1, dvz=0, q_out=1111111111, valid 15 edges after start.
REQ-027 a=0000011000 (1.5), b=0000001000 (0.5) -> q_out=0000110000 (3.0), ovf=0, dvz=0.
REQ-028 a=0000010000 (1.0), b=0000110000 (3.0) -> q_out=0000000101 (0.3125, truncated).
REQ-029 a=any, b=0000000000 -> dvz=1, q_out=0, valid 2 edges after start, busy high 1 cycle.
REQ-030 a=b=1111111111 -> q_out=0000010000 (1.0); then sclr=0 mid-CALC on a second operation -> all outputs 0, no valid pulse.
REQ-031 start held high across three operations -> each valid pulse followed by exactly one idle cycle before busy rises; changing a_in/b_in during CALC does not alter the result.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the Q6.4 unsigned fixed-point divider.
// Holds the operand width, fraction width, iteration count and the
// controller state enumeration used by divider and divider_datapath.
package divider_pkg;

  localparam int WIDTH = 10;
  localparam int FRAC  = 4;
  localparam int ITER  = 14;

  // The numerator is the dividend pre-scaled by 2^FRAC so the integer
  // quotient lands directly in Q6.4 format.
  localparam int NUM_W = WIDTH + FRAC;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_datapath.sv
// Datapath for the restoring shift-subtract divider.
// Holds the captured divisor, the partial remainder, the shifting
// numerator/quotient register and the registered results.
//
// Ports:
//   clk          clock, all state changes on rising edge
//   sclr         synchronous active-low clear
//   load_i       capture operands and clear the flags
//   iterate_i    perform one shift-subtract step
//   finishCalc_i register the quotient (with saturation) on the last step
//   finishDvz_i  register the divide-by-zero result
//   a_i, b_i     dividend and divisor, unsigned Q6.4
//   bZero_o      captured divisor is zero
//   q_o          quotient, unsigned Q6.4
//   dvz_o        divide-by-zero flag
//   ovf_o        overflow flag
module divider_datapath
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             sclr,
  input  logic             load_i,
  input  logic             iterate_i,
  input  logic             finishCalc_i,
  input  logic             finishDvz_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             bZero_o,
  output logic [WIDTH-1:0] q_o,
  output logic             dvz_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic             dvz_q, dvz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic             remGe;
  logic [NUM_W-1:0] quotStep;

  // One restoring step: bring the next numerator bit into the remainder,
  // subtract the divisor if it fits, and shift the resulting quotient bit
  // into the vacated low end of the numerator register. The remainder
  // always ends below the divisor, so WIDTH bits are enough to keep it.
  always_comb begin
    remShift = {rem_q, quot_q[NUM_W-1]};
    remDiff  = remShift - {1'b0, divisor_q};
    remGe    = (remShift >= {1'b0, divisor_q});
    quotStep = {quot_q[NUM_W-2:0], remGe};
  end

  // Next-state selection for the datapath registers.
  always_comb begin
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    qOut_d    = qOut_q;
    dvz_d     = dvz_q;
    ovf_d     = ovf_q;

    if (load_i) begin
      divisor_d = b_i;
      rem_d     = '0;
      quot_d    = {a_i, {FRAC{1'b0}}};
      dvz_d     = 1'b0;
      ovf_d     = 1'b0;
    end else if (iterate_i) begin
      rem_d  = remGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
      quot_d = quotStep;
    end

    // Any quotient bit above the Q6.4 range means the result cannot be
    // represented, so it saturates to all ones.
    if (finishCalc_i) begin
      ovf_d  = |quotStep[NUM_W-1:WIDTH];
      qOut_d = (|quotStep[NUM_W-1:WIDTH]) ? '1 : quotStep[WIDTH-1:0];
    end

    if (finishDvz_i) begin
      dvz_d  = 1'b1;
      ovf_d  = 1'b0;
      qOut_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      qOut_q    <= '0;
      dvz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      qOut_q    <= qOut_d;
      dvz_q     <= dvz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bZero_o = (divisor_q == '0);
  assign q_o     = qOut_q;
  assign dvz_o   = dvz_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/divider.sv
// Unsigned Q6.4 fixed-point divider, top level.
// A three-state controller (IDLE, CALC, DONE) sequences a restoring
// shift-subtract datapath through 14 iterations, or short-circuits
// straight to DONE when the captured divisor is zero.
//
// Ports:
//   clk    clock, all state changes on rising edge
//   sclr   synchronous active-low clear, wins over start
//   a_in   dividend, unsigned Q6.4
//   b_in   divisor, unsigned Q6.4
//   start  level request, sampled only in IDLE
//   q_out  quotient, truncated, saturated to 10'h3FF on overflow
//   dvz    divide-by-zero flag of the last operation
//   ovf    overflow flag of the last operation
//   busy   operation in progress (CALC)
//   valid  one-cycle pulse when results become valid (DONE)
module divider
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             sclr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  output logic [WIDTH-1:0] q_out,
  output logic             dvz,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iterCnt_q, iterCnt_d;

  logic load;
  logic iterate;
  logic finishCalc;
  logic finishDvz;
  logic bZero;

  divider_datapath uDatapath (
    .clk          (clk),
    .sclr         (sclr),
    .load_i       (load),
    .iterate_i    (iterate),
    .finishCalc_i (finishCalc),
    .finishDvz_i  (finishDvz),
    .a_i          (a_in),
    .b_i          (b_in),
    .bZero_o      (bZero),
    .q_o          (q_out),
    .dvz_o        (dvz),
    .ovf_o        (ovf)
  );

  // Controller next-state logic. The iteration counter runs 0..ITER-1
  // inside CALC; the step taken at ITER-1 is also the one that registers
  // the result, so DONE is entered on the 14th iteration edge.
  always_comb begin
    state_d    = state_q;
    iterCnt_d  = iterCnt_q;
    load       = 1'b0;
    iterate    = 1'b0;
    finishCalc = 1'b0;
    finishDvz  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          iterCnt_d = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (bZero) begin
          finishDvz = 1'b1;
          state_d   = DONE;
        end else begin
          iterate = 1'b1;
          if (iterCnt_q == CNT_W'(ITER - 1)) begin
            finishCalc = 1'b1;
            state_d    = DONE;
          end else begin
            iterCnt_d = iterCnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sclr) begin
      state_q   <= IDLE;
      iterCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      iterCnt_q <= iterCnt_d;
    end
  end

  assign busy  = (state_q == CALC);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the Q6.4 divider. Expected results come from a
// behavioural model, are queued when an operation is launched and popped
// when the divider raises valid.
module tb_divider;

  typedef struct packed {
    logic [9:0] q;
    logic       dvz;
    logic       ovf;
    int         lat;
  } exp_t;

  logic       clk;
  logic       sclr;
  logic [9:0] aIn;
  logic [9:0] bIn;
  logic       start;
  logic [9:0] qOut;
  logic       dvz;
  logic       ovf;
  logic       busy;
  logic       valid;

  int   errors;
  int   checks;
  exp_t sb[$];

  divider dut (
    .clk   (clk),
    .sclr  (sclr),
    .a_in  (aIn),
    .b_in  (bIn),
    .start (start),
    .q_out (qOut),
    .dvz   (dvz),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  // 10 ns clock; all stimulus and sampling happens on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: floor(a*16/b) with saturation and div-by-zero.
  function automatic exp_t modelOf(input logic [9:0] a, input logic [9:0] b);
    exp_t r;
    int   num;
    int   quo;
    num = int'(a) * 16;
    if (b == 10'd0) begin
      r.q = 10'd0; r.dvz = 1'b1; r.ovf = 1'b0; r.lat = 2;
    end else begin
      quo = num / int'(b);
      r.dvz = 1'b0;
      r.lat = 15;
      if (quo > 1023) begin
        r.q = 10'h3FF; r.ovf = 1'b1;
      end else begin
        r.q = quo[9:0]; r.ovf = 1'b0;
      end
    end
    return r;
  endfunction

  // Launch one operation from a falling edge and wait (bounded) for valid.
  // lat counts rising edges from the start-sampling edge (which is edge 1).
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, output int lat);
    aIn   = a;
    bIn   = b;
    start = 1'b1;
    sb.push_back(modelOf(a, b));
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    sclr  = 1'b0;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (qOut !== 10'd0 || dvz !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got q=%h dvz=%b ovf=%b busy=%b valid=%b, want all 0",
               qOut, dvz, ovf, busy, valid);
    end
    // sclr low together with start: reset must win.
    aIn   = 10'd24;
    bIn   = 10'd8;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_priority: got busy=%b valid=%b, want 0 0", busy, valid);
    end
    start = 1'b0;
    sclr  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int   lat;
    exp_t e;
    applyStimulus(10'b0101010000, 10'b0000000100, lat);
    e = sb.pop_front();
    checks++;
    if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL overflow: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
               qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_busy_at_valid: got busy=%b, want 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   lat;
    exp_t e;
    applyStimulus(10'b0000011000, 10'b0000001000, lat);
    e = sb.pop_front();
    checks++;
    if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL basic_1p5_div_0p5: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
               qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
    end
    @(negedge clk);

    applyStimulus(10'b0000010000, 10'b0000110000, lat);
    e = sb.pop_front();
    checks++;
    if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL basic_1_div_3: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
               qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
    end
    // Results must hold after the valid pulse while idle.
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf) begin
      errors++;
      $display("[TB] FAIL result_hold: got valid=%b q=%h dvz=%b ovf=%b, want valid=0 q=%h dvz=%b ovf=%b",
               valid, qOut, dvz, ovf, e.q, e.dvz, e.ovf);
    end
  endtask

  task automatic test_div_by_zero;
    int   lat;
    exp_t e;
    aIn   = 10'h2AB;
    bIn   = 10'd0;
    start = 1'b1;
    sb.push_back(modelOf(aIn, bIn));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dvz_busy_cycle: got busy=%b valid=%b, want 1 0", busy, valid);
    end
    lat = 2;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL div_by_zero: got valid=%b busy=%b q=%h dvz=%b ovf=%b, want valid=1 busy=0 q=%h dvz=%b ovf=%b",
               valid, busy, qOut, dvz, ovf, e.q, e.dvz, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dvz_valid_pulse: got valid=%b one cycle later, want 0", valid);
    end
  endtask

  task automatic test_max_and_abort;
    int   lat;
    int   seenValid;
    exp_t e;
    applyStimulus(10'h3FF, 10'h3FF, lat);
    e = sb.pop_front();
    checks++;
    if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL max_div_max: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
               qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
    end
    @(negedge clk);

    // Second operation, aborted by sclr partway through CALC.
    aIn   = 10'd100;
    bIn   = 10'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    sclr = 1'b0;
    @(negedge clk);
    sclr = 1'b1;
    checks++;
    if (qOut !== 10'd0 || dvz !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got q=%h dvz=%b ovf=%b busy=%b valid=%b, want all 0",
               qOut, dvz, ovf, busy, valid);
    end
    seenValid = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) seenValid++;
    end
    checks++;
    if (seenValid !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d active cycles after abort, want 0", seenValid);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] opA[3];
    logic [9:0] opB[3];
    int         lat;
    exp_t       e;
    opA[0] = 10'd24;  opB[0] = 10'd8;
    opA[1] = 10'd16;  opB[1] = 10'd48;
    opA[2] = 10'd336; opB[2] = 10'd4;
    aIn   = opA[0];
    bIn   = opB[0];
    start = 1'b1;
    sb.push_back(modelOf(opA[0], opB[0]));
    for (int k = 0; k < 3; k++) begin
      lat = 1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_busy_rise op%0d: got busy=%b, want 1", k, busy);
      end
      // Change operands mid-CALC; they become the next operation's inputs.
      if (k < 2) begin
        aIn = opA[k+1];
        bIn = opB[k+1];
        sb.push_back(modelOf(opA[k+1], opB[k+1]));
      end
      while (valid !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b2b_scoreboard op%0d: got empty queue, want one entry", k);
      end else begin
        e = sb.pop_front();
        checks++;
        if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
          errors++;
          $display("[TB] FAIL b2b_result op%0d: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
                   k, qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
        end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_idle_gap op%0d: got busy=%b valid=%b, want 0 0", k, busy, valid);
      end
      if (k == 2) start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int         lat;
    exp_t       e;
    logic [9:0] a;
    logic [9:0] b;
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = (i == 3) ? 10'd0 : 10'($urandom_range(1, 1023));
      applyStimulus(a, b, lat);
      e = sb.pop_front();
      checks++;
      if (qOut !== e.q || dvz !== e.dvz || ovf !== e.ovf || lat !== e.lat) begin
        errors++;
        $display("[TB] FAIL random a=%h b=%h: got q=%h dvz=%b ovf=%b lat=%0d, want q=%h dvz=%b ovf=%b lat=%0d",
                 a, b, qOut, dvz, ovf, lat, e.q, e.dvz, e.ovf, e.lat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sclr   = 1'b0;
    start  = 1'b0;
    aIn    = '0;
    bIn    = '0;
    @(negedge clk);
    test_reset;
    test_overflow;
    test_basic;
    test_div_by_zero;
    test_max_and_abort;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
